// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode, flag types and saturation helper for the add/sub pipeline
package alu_pipe_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, ADC = 2'd2, SBB = 2'd3} alu_op_t;
  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;
  function automatic logic [63:0] sat_value(input int width, input logic sign);
    logic [63:0] smax;
    smax = (64'd1 << (width - 1)) - 64'd1;
    return sign ? ~smax : smax;
  endfunction
endpackage

// File: rtl/alu_pipe_core.sv
// alu_core: combinational add/sub with carry chaining, optional signed saturation and flags
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  alu_op_t        op,
  input  logic           sat,
  input  logic           cin,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output alu_flags_t     flags
);
  logic         sub;
  logic         ci;
  logic [W:0]   sum;
  logic         ovf;
  always_comb begin
    sub    = op == SUB || op == SBB;
    ci     = (op == ADC || op == SBB) && cin;
    sum    = sub ? {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci} : {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    ovf    = (sub ? a[W-1] != b[W-1] : a[W-1] == b[W-1]) && sum[W-1] != a[W-1];
    result = sat && ovf ? W'(sat_value(W, a[W-1])) : sum[W-1:0];
    flags  = '{c: sum[W], v: ovf, z: result == '0, n: result[W-1]};
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: operand register, add/sub core and PIPE_STAGES result registers under one shared stall
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_op_t               op_in,
  input  logic                  sat_in,
  input  logic                  carry_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  carry_out,
  output logic                  ovf_out,
  output logic                  zero_out,
  output logic                  neg_out
);
  logic                  in_v;
  alu_op_t               op_q;
  logic                  sat_q;
  logic                  cin_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] core_res;
  alu_flags_t            core_flg;
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_v  <= 1'b0;
      op_q  <= ADD;
      sat_q <= 1'b0;
      cin_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (in_ready) begin
      in_v <= in_valid;
      if (in_valid) begin
        op_q  <= op_in;
        sat_q <= sat_in;
        cin_q <= carry_in;
        a_q   <= a_in;
        b_q   <= b_in;
      end
    end
  alu_core #(.W(DATA_WIDTH)) u_core (
    .op(op_q), .sat(sat_q), .cin(cin_q), .a(a_q), .b(b_q),
    .result(core_res), .flags(core_flg)
  );
  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_st
    logic                  v;
    logic [DATA_WIDTH-1:0] r;
    alu_flags_t            f;
    logic                  v_d;
    logic [DATA_WIDTH-1:0] r_d;
    alu_flags_t            f_d;
    if (i == 0) begin : g_first
      assign v_d = in_v;
      assign r_d = core_res;
      assign f_d = core_flg;
    end else begin : g_next
      assign v_d = g_st[i-1].v;
      assign r_d = g_st[i-1].r;
      assign f_d = g_st[i-1].f;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= 1'b0;
        r <= '0;
        f <= '0;
      end else if (in_ready) begin
        v <= v_d;
        r <= r_d;
        f <= f_d;
      end
  end
  assign out_valid  = g_st[PIPE_STAGES-1].v;
  assign result_out = g_st[PIPE_STAGES-1].r;
  assign {carry_out, ovf_out, zero_out, neg_out} = g_st[PIPE_STAGES-1].f;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors plus a scoreboarded random run for alu_pipe
module tb_alu_pipe;
  import alu_pipe_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  alu_op_t    op_in = ADD;
  logic       sat_in = 1'b0;
  logic       carry_in = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result_out;
  logic       carry_out, ovf_out, zero_out, neg_out;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [11:0] q[$];
  logic       rnd_done;
  always #5 clk = ~clk;
  alu_pipe #(.DATA_WIDTH(8), .PIPE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_in(op_in), .sat_in(sat_in), .carry_in(carry_in), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
    .carry_out(carry_out), .ovf_out(ovf_out), .zero_out(zero_out), .neg_out(neg_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] model(input alu_op_t op, input logic s, input logic c,
                                        input logic [7:0] a, input logic [7:0] b);
    int ci = (op == ADC || op == SBB) ? int'(c) : 0;
    bit sub = op == SUB || op == SBB;
    int u = sub ? int'(a) - int'(b) - ci : int'(a) + int'(b) + ci;
    int sv = sub ? int'($signed(a)) - int'($signed(b)) - ci : int'($signed(a)) + int'($signed(b)) + ci;
    logic cf = sub ? u < 0 : u > 255;
    logic vf = sv > 127 || sv < -128;
    logic [7:0] r = u[7:0];
    if (s && vf) r = sv > 127 ? 8'h7F : 8'h80;
    return {r, cf, vf, r == 8'h00, r[7]};
  endfunction
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
      else begin
        logic [11:0] e;
        e = q.pop_front();
        check("result", {24'd0, result_out}, {24'd0, e[11:4]});
        check("flags_cvzn", {28'd0, carry_out, ovf_out, zero_out, neg_out}, {28'd0, e[3:0]});
      end
    end
  // called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input alu_op_t op, input logic s, input logic c, input logic [7:0] a,
                      input logic [7:0] b, input logic [11:0] exp);
    logic rdy;
    int   t = 0;
    in_valid = 1'b1; op_in = op; sat_in = s; carry_in = c; a_in = a; b_in = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 100);
    if (!rdy) check("in_ready_timeout", 32'd0, 32'd1);
    else q.push_back(exp);
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_left", q.size(), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] snap;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {23'd0, result_out, carry_out, ovf_out, zero_out, neg_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(ADD, 1'b0, 1'b0, 8'h64, 8'h21, {8'h85, 4'b0101});
    check("lat_edge0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2", {31'd0, out_valid}, 32'd1);
    send(SUB, 1'b0, 1'b0, 8'h10, 8'h20, {8'hF0, 4'b1001});
    send(ADC, 1'b0, 1'b1, 8'hFF, 8'h00, {8'h00, 4'b1010});
    send(ADD, 1'b1, 1'b0, 8'h7F, 8'h01, {8'h7F, 4'b0100});
    send(SUB, 1'b1, 1'b0, 8'h80, 8'h01, {8'h80, 4'b0101});
    send(ADD, 1'b0, 1'b0, 8'h7F, 8'h01, {8'h80, 4'b0101});
    send(SUB, 1'b0, 1'b0, 8'h80, 8'h01, {8'h7F, 4'b0100});
    drain();
    fork
      begin
        send(ADD, 1'b0, 1'b0, 8'h01, 8'h02, {8'h03, 4'b0000});
        send(SUB, 1'b0, 1'b0, 8'h05, 8'h05, {8'h00, 4'b0010});
        send(ADC, 1'b0, 1'b1, 8'h0F, 8'h01, {8'h11, 4'b0000});
        send(SBB, 1'b0, 1'b1, 8'h00, 8'h00, {8'hFF, 4'b1001});
        send(ADD, 1'b0, 1'b0, 8'h80, 8'h80, {8'h00, 4'b1110});
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        snap = result_out;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_out_valid", {31'd0, out_valid}, 32'd1);
          check("stall_result", {24'd0, result_out}, {24'd0, snap});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    send(ADD, 1'b0, 1'b0, 8'h11, 8'h22, {8'h33, 4'b0000});
    send(SUB, 1'b0, 1'b0, 8'h40, 8'h01, {8'h3F, 4'b0000});
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outputs", {23'd0, result_out, carry_out, ovf_out, zero_out, neg_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    send(ADD, 1'b0, 1'b0, 8'h12, 8'h34, {8'h46, 4'b0000});
    @(posedge clk);
    #1;
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_lat2", {31'd0, out_valid}, 32'd1);
    drain();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          alu_op_t    op;
          logic       s, c;
          logic [7:0] a, b;
          op = alu_op_t'($urandom_range(0, 3));
          s = 1'($urandom_range(0, 1));
          c = 1'($urandom_range(0, 1));
          a = 8'($urandom);
          b = 8'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(op, s, c, a, b, model(op, s, c, a, b));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
